// File: rtl/fx16be_pack_pkg.sv
// ============================================================================
// Module   : fx16be_pack_pkg
// Brief    : Shared FP32 / FX16 field layout and constants for the 16-bit
//            big-endian stream converters.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fx16be_pack_pkg;

  // FP32 field layout: sign | exp[30:23] | mant[22:0]
  localparam int c_fp32_w        = 32;
  localparam int c_fp32_sign_pos = 31;
  localparam int c_fp32_exp_msb  = 30;
  localparam int c_fp32_exp_lsb  = 23;
  localparam int c_fp32_exp_w    = 8;
  localparam int c_fp32_mant_w   = 23;
  localparam int c_fp32_exp_bias = 127;

  localparam logic [c_fp32_exp_w-1:0] c_fp32_exp_max = 8'hFF;

  localparam int              c_fx16_w   = 16;
  localparam logic [15:0]     c_fx16_max = 16'h7FFF;
  localparam logic [15:0]     c_fx16_min = 16'h8000;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_SAT  = 2'd1,
    CLS_NORM = 2'd2
  } conv_cls_t;

  function automatic logic fp32_sign(input logic [c_fp32_w-1:0] x);
    return x[c_fp32_sign_pos];
  endfunction

  function automatic logic [c_fp32_exp_w-1:0] fp32_exp(input logic [c_fp32_w-1:0] x);
    return x[c_fp32_exp_msb:c_fp32_exp_lsb];
  endfunction

  function automatic logic [c_fp32_mant_w-1:0] fp32_mant(input logic [c_fp32_w-1:0] x);
    return x[c_fp32_mant_w-1:0];
  endfunction

  function automatic logic [c_fx16_w-1:0] fx16_rail(input logic neg);
    return neg ? c_fx16_min : c_fx16_max;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx16be_pack_fp32_to_fx16.sv
// ============================================================================
// Module   : fp32_to_fx16
// Brief    : Two-stage FP32 -> signed Q(15-F).F converter with stall enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp32_to_fx16
  import fx16be_pack_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic                i_last,
  input  logic [c_fp32_w-1:0] i_data,
  output logic                o_valid,
  output logic                o_last,
  output logic [c_fx16_w-1:0] o_res,
  output logic                o_sat
);

  // Thresholds on exp+FRAC_BITS: >=143 means magnitude >= 2^16, <126 means < 0.5
  localparam logic [8:0] c_ef_sat  = 9'(c_fp32_exp_bias + c_fx16_w);
  localparam logic [8:0] c_ef_zero = 9'(c_fp32_exp_bias - 1);
  localparam logic [8:0] c_rsh_base = 9'(c_fp32_exp_bias + c_fp32_mant_w);

  // ---------------- Stage 1: unpack and classify ----------------
  logic                     w_sign;
  logic [c_fp32_exp_w-1:0]  w_exp;
  logic [c_fp32_mant_w-1:0] w_mant;
  logic [8:0]               w_ef;
  logic [4:0]               w_rsh;
  conv_cls_t                w_cls;

  assign w_sign = fp32_sign(i_data);
  assign w_exp  = fp32_exp(i_data);
  assign w_mant = fp32_mant(i_data);
  assign w_ef   = {1'b0, w_exp} + 9'(FRAC_BITS);
  assign w_rsh  = 5'(c_rsh_base - w_ef);

  always_comb begin
    w_cls = CLS_NORM;
    if (w_exp == '0) begin
      w_cls = CLS_ZERO;
    end else if (w_exp == c_fp32_exp_max) begin
      w_cls = (w_mant != '0) ? CLS_ZERO : CLS_SAT;
    end else if (w_ef >= c_ef_sat) begin
      w_cls = CLS_SAT;
    end else if (w_ef < c_ef_zero) begin
      w_cls = CLS_ZERO;
    end
  end

  logic        r_v1;
  logic        r_last1;
  logic        r_sign1;
  conv_cls_t   r_cls1;
  logic [23:0] r_sig1;
  logic [4:0]  r_rsh1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
      r_sign1 <= 1'b0;
      r_cls1  <= CLS_ZERO;
      r_sig1  <= '0;
      r_rsh1  <= '0;
    end else if (i_en) begin
      r_v1    <= i_valid;
      r_last1 <= i_last;
      r_sign1 <= w_sign;
      r_cls1  <= w_cls;
      r_sig1  <= {1'b1, w_mant};
      r_rsh1  <= w_rsh;
    end
  end

  // ---------------- Stage 2: round half away, saturate ----------------
  // For CLS_NORM the right shift is 8..24, so the rounded magnitude fits 17 bits.
  logic [24:0]         w_half;
  logic [24:0]         w_sum;
  logic [16:0]         w_mag;
  logic [c_fx16_w-1:0] w_res;
  logic                w_sat;

  assign w_half = 25'd1 << (r_rsh1 - 5'd1);
  assign w_sum  = {1'b0, r_sig1} + w_half;
  assign w_mag  = 17'(w_sum >> r_rsh1);

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    case (r_cls1)
      CLS_SAT: begin
        w_res = fx16_rail(r_sign1);
        w_sat = 1'b1;
      end
      CLS_NORM: begin
        if (!r_sign1) begin
          if (w_mag >= 17'h08000) begin
            w_res = c_fx16_max;
            w_sat = 1'b1;
          end else begin
            w_res = w_mag[15:0];
          end
        end else begin
          // -2^15 is representable exactly; only strictly larger magnitudes clip
          if (w_mag > 17'h08000) begin
            w_res = c_fx16_min;
            w_sat = 1'b1;
          end else begin
            w_res = ~w_mag[15:0] + 16'd1;
          end
        end
      end
      default: begin
        w_res = '0;
        w_sat = 1'b0;
      end
    endcase
  end

  logic                r_v2;
  logic                r_last2;
  logic [c_fx16_w-1:0] r_res2;
  logic                r_sat2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
      r_res2  <= '0;
      r_sat2  <= 1'b0;
    end else if (i_en) begin
      r_v2    <= r_v1;
      r_last2 <= r_last1;
      r_res2  <= w_res;
      r_sat2  <= w_sat && r_v1;
    end
  end

  assign o_valid = r_v2;
  assign o_last  = r_last2;
  assign o_res   = r_res2;
  assign o_sat   = r_sat2;

endmodule

`default_nettype wire

// File: rtl/fx16be_pack.sv
// ============================================================================
// Module   : fx16be_pack
// Brief    : FP32 stream -> packed big-endian pairs of signed 16-bit fixed point.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fx16be_pack
  import fx16be_pack_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] sat_cnt
);

  logic                w_adv;
  logic                w_cv;
  logic                w_cl;
  logic                w_csat;
  logic [c_fx16_w-1:0] w_cres;

  logic                r_out_valid;
  logic                r_out_last;
  logic [31:0]         r_out_data;
  logic                r_have_half;
  logic [c_fx16_w-1:0] r_half;
  logic [15:0]         r_sat_cnt;

  // One global enable: the whole pipe freezes while a word waits for the consumer
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  fp32_to_fx16 #(
    .FRAC_BITS (FRAC_BITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_adv),
    .i_valid (in_valid),
    .i_last  (in_last),
    .i_data  (in_data),
    .o_valid (w_cv),
    .o_last  (w_cl),
    .o_res   (w_cres),
    .o_sat   (w_csat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_have_half <= 1'b0;
      r_half      <= '0;
      r_sat_cnt   <= '0;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
      if (w_cv) begin
        if (r_have_half) begin
          r_out_data  <= {r_half, w_cres};
          r_out_valid <= 1'b1;
          r_out_last  <= w_cl;
          r_have_half <= 1'b0;
        end else if (w_cl) begin
          // Odd-length frame: flush the lone sample with a zero low half
          r_out_data  <= {w_cres, 16'h0000};
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b1;
        end else begin
          r_half      <= w_cres;
          r_have_half <= 1'b1;
        end
      end
      if (w_cv && w_csat && (r_sat_cnt != 16'hFFFF)) begin
        r_sat_cnt <= r_sat_cnt + 16'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign sat_cnt   = r_sat_cnt;

endmodule

`default_nettype wire

// File: doc/fx16be_pack.md
# fx16be_pack

Stream packer that converts IEEE-754 single-precision samples to signed 16-bit fixed-point and packs two results per 32-bit big-endian word. It is the output-side counterpart of `convert_bit`: `convert_bit` expands 16-bit big-endian data into 32-bit values, and this block narrows processed 32-bit results back into the 16-bit big-endian memory format. It sits between the compute datapath and the result write-back buffer, using valid/ready handshakes on both sides.

## Interface
- `FRAC_BITS`, 8: fractional bits of the fixed-point output (Q(15-FRAC_BITS).FRAC_BITS).
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 32: fp32 sample (sign, exp[30:23], mant[22:0]).
- `in_valid` in 1: `in_data`/`in_last` are valid.
- `in_last` in 1: final sample of a frame.
- `in_ready` out 1: block accepts a sample this cycle.
- `out_data` out 32: packed word, first sample in [31:16], second in [15:0].
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: word holds the frame's final sample.
- `out_ready` in 1: consumer accepts the word.
- `sat_cnt` out 16: saturating count of saturated conversions since reset.

## Operation
- Conversion per sample (e = exp-127, F = FRAC_BITS, magnitude M = 1.mant·2^(e+F)):
  - exp==0 (zero/denormal): result 0x0000.
  - exp==255, mant!=0 (NaN): 0x0000, no saturation count.
  - exp==255, mant==0 (±inf): saturate.
  - e+F < -1: 0x0000.
  - Rounding of M is round-half-away-from-zero on magnitude, then negation if sign=1.
  - M ≥ 2^15 positive: 0x7FFF, saturated.
  - M > 2^15 negative: 0x8000, saturated.
  - Negative M == 2^15 exactly: 0x8000, not saturated.
- Each saturation increments `sat_cnt`; the counter sticks at 0xFFFF.
- Packer holds one pending half-word.
  - First sample of a pair goes to [31:16].
  - Second sample completes the word.
  - If `in_last` is on the first half, the word is emitted immediately with [15:0]=0x0000 and `out_last`=1.
  - After any last word, pairing restarts at [31:16].
- Global advance: `advance = !out_valid || out_ready`, and `in_ready = advance` (combinational). All pipeline stages and the packer move only when `advance`=1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `sat_cnt`=0.
- All stage-valid bits and the pending half are cleared on reset, so `in_ready`=1 in the first cycle after reset.
- Pipeline:
  - S1 registers the unpacked fields and the shift amount.
  - S2 registers the rounded, saturated 16-bit result.
  - The packer register drives the outputs.
- Latency: the sample completing a word is accepted in cycle t; `out_valid`=1 in cycle t+3 (no stall).
- Throughput: 1 sample/cycle and 1 word per 2 cycles.
- Output is held stable while `out_valid && !out_ready`. Inputs are ignored unless `in_valid && in_ready`.
- Reset mid-frame discards any pending half-word and in-flight samples, with no partial word output.
- Bubbles (`in_valid`=0) do not break pairing; the pending half waits indefinitely.

## Structure
- Shared package/header holds:
  - FP32 field widths and positions.
  - Exponent bias 127.
  - FX16 max 0x7FFF and min 0x8000.
- The same constants are used by `convert_bit`.
- Sub-module `fp32_to_fx16`: the 2-stage conversion datapath with stall enable. It outputs result, valid, last, and a saturation flag.
- The top level holds the packer, handshake logic and `sat_cnt`.

## Test plan
- Pairing: 0x3F800000 (1.0), 0xC0200000 (-2.5) with `out_ready`=1 -> `out_data`=0x0100FD80 three cycles after the second accept, `out_last`=0.
- Saturation: 0x43960000 (300.0) and 0xC3480000 (-200.0) -> 0x7FFF8000, `sat_cnt`=2. Then 0xC3000000 (-128.0) with `in_last` -> 0x80000000, `out_last`=1, `sat_cnt` stays 2.
- Rounding/specials: 0x3B000000 (2^-9) and 0x7FC00000 (NaN) -> 0x00010000. Then 0xFF800000 (-inf) and 0x00000001 (denormal) -> 0x80000000, `sat_cnt`+1.
- Backpressure: stream 8 samples with `out_ready` toggling 1,0,0,1… -> 4 words in order, each held stable while stalled, and `in_ready` low exactly when `out_valid && !out_ready`.
- Reset mid-operation: accept 0x3F800000, assert `rst` one cycle -> no output. Then 0x3F000000, 0x3F000000 -> 0x00800080 as the first word.
